// File: rtl/systolic_result_drain_pkg.sv
// Shared definitions for the systolic result drain: FSM encoding and row-index width.
package systolic_result_drain_pkg;

    localparam int ROW_IDX_W = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } drain_state_e;

endpackage

// File: rtl/systolic_result_drain_sync_row_fifo.sv
// Synchronous row FIFO with extra-MSB pointers; a push while full is accepted only
// when the head is popped in the same cycle.
module sync_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign rd_en    = pop_i & ~empty_o;
    assign wr_en    = push_i & (~full_o | rd_en);
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/systolic_result_drain.sv
// De-skews bottom-row systolic results into whole rows and streams them out through a row FIFO.
//  state   | meaning
//  IDLE    | waiting for start
//  WAIT    | counting down until row 0 is aligned at the delay-line outputs
//  CAPTURE | pushing one aligned row per cycle, M rows
//  DRAIN   | waiting for the FIFO to empty, then pulse done
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int N          = 4,
    parameter int ACC_W      = 32,
    parameter int LAT        = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          num_rows,
    input  logic [N*ACC_W-1:0]   col_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*ACC_W-1:0]   out_data,
    output logic [15:0]          out_row,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int DW        = N * ACC_W;
    localparam int FW        = DW + ROW_IDX_W + 1;
    localparam int CW        = $clog2(FIFO_DEPTH);
    localparam int WAIT_W    = $clog2(LAT + N);
    localparam int WAIT_INIT = LAT + N - 3;

    drain_state_e         state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [ROW_IDX_W-1:0] row_q, row_d;
    logic [ROW_IDX_W-1:0] m_q, m_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;

    logic [DW-1:0]        aligned;
    logic                 push, pop, row_last, drain_fin;
    logic [FW-1:0]        fifo_rd;
    logic                 fifo_full, fifo_empty;
    logic [CW:0]          fifo_count;

    // Lane j waits N-1-j cycles so every lane of a row lines up with lane N-1.
    for (genvar j = 0; j < N; j++) begin : g_lane
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j*ACC_W +: ACC_W] = col_c[j*ACC_W +: ACC_W];
        end else begin : g_dly
            logic [ACC_W-1:0] dly_q [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) dly_q[k] <= '0;
                end else begin
                    dly_q[0] <= col_c[j*ACC_W +: ACC_W];
                    for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
                end
            end
            assign aligned[j*ACC_W +: ACC_W] = dly_q[D-1];
        end
    end

    sync_row_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .data_i  ({row_q, row_last, aligned}),
        .pop_i   (pop),
        .data_o  (fifo_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign {out_row, out_last, out_data} = out_valid ? fifo_rd : '0;
    assign row_last  = (row_q == m_q - 16'd1);
    assign drain_fin = fifo_empty | (pop & (fifo_count == (CW+1)'(1)));
    assign done      = done_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            row_q      <= '0;
            m_q        <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            row_q      <= row_d;
            m_q        <= m_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        row_d   = row_q;
        m_d     = m_q;
        case (state_q)
            S_IDLE: begin
                if (start && num_rows != 16'd0) begin
                    state_d = S_WAIT;
                    wait_d  = WAIT_W'(WAIT_INIT);
                    row_d   = '0;
                    m_d     = num_rows;
                end
            end
            S_WAIT: begin
                if (wait_q == '0) state_d = S_CAPTURE;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_CAPTURE: begin
                row_d = row_q + 16'd1;
                if (row_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_fin) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push   = 1'b0;
        done_d = 1'b0;
        busy   = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:    done_d = start & (num_rows == 16'd0);
            S_CAPTURE: push   = 1'b1;
            S_DRAIN:   done_d = drain_fin;
            default:   ;
        endcase
        // A row is lost only when the FIFO stays full across this edge.
        overflow_d = overflow_q | (push & fifo_full & ~pop);
    end

endmodule
